pio_stream_seq: RTL and testbench
=================================

Name: pio_stream_seq

Overview:
- Parametrised PIO bring-up and streaming sequencer.
- Loads a program image into a pio instance, then applies a variable-length list of configuration actions.
- Then streams a byte message into the TX FIFO of a selectable state machine, with pacing, backpressure, repeat mode and abort.
- Sits between top-level glue and pio; its memories are written through a host write port instead of fixed at build time.

Parameters:
PROG_LEN, 32, instructions loaded per start (1..32); pio instruction index is 5 bits
CONF_MAX, 32, configuration memory depth (power of 2)
MSG_MAX, 64, message memory depth in bytes (power of 2)
GAP_W, 12, width of inter-push gap counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
wr_en  in  1  host write strobe
wr_sel  in  2  0=program, 1=config, 2=message, 3=ignored
wr_addr  in  6  word/byte address; upper bits beyond memory depth ignored
wr_data  in  36  program: [15:0]; config: [35:32] action, [31:0] data; message: [7:0]
start  in  1  one-cycle start pulse
cfg_mindex  in  2  target state machine for PUSH
cfg_conf_len  in  $clog2(CONF_MAX)+1  config entries to apply (0..CONF_MAX)
cfg_msg_len  in  $clog2(MSG_MAX)+1  message bytes (0..MSG_MAX)
cfg_gap  in  GAP_W  idle cycles between pushes
cfg_repeat  in  1  1=loop message until abort
abort  in  1  return to IDLE
pio_action  out  6  action to pio
pio_din  out  32  data to pio
pio_index  out  5  instruction index to pio
pio_mindex  out  2  machine index to pio
pio_tx_full  in  4  TX FIFO full flags from pio
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse on normal completion
stall_cnt  out  16  saturating count of blocked push cycles

Behaviour:
- Reset: all outputs 0; state IDLE; stall_cnt 0. Memory contents are not cleared.
- All pio_* outputs are registered. Memories are reg arrays with asynchronous read.
- Writes are accepted only in IDLE and are ignored while busy=1.
- IDLE: pio_action=0.
  - start latches every cfg_* field, clears stall_cnt and enters LOAD_PROG.
  - start while busy is ignored.
- LOAD_PROG: for p=0..PROG_LEN-1, one cycle each: pio_action=1, pio_index=p, pio_din={16'b0,prog[p]}.
  - Start sampled at edge N -> first load visible after edge N+1.
  - Lasts exactly PROG_LEN cycles, then enters LOAD_CONF.
- LOAD_CONF: for c=0..conf_len-1, one cycle each: pio_action=conf[c][35:32] zero-extended, pio_din=conf[c][31:0].
  - conf_len=0: pio_action=0 for one cycle, then STREAM.
  - Entering STREAM always drives pio_action=0 for one cycle.
- STREAM: pio_mindex=latched mindex throughout.
  - msg_len=0: enter DONE.
  - Push: when gap_cnt==0 and pio_tx_full[mindex]==0, drive one cycle pio_action=4, pio_din={24'b0,msg[i]}.
  - Next cycle: pio_action=0 and gap_cnt loads max(cfg_gap,1), so two consecutive PUSH cycles never occur.
  - gap_cnt decrements each cycle while nonzero.
  - Blocked: when gap_cnt==0 and tx_full is set, no push occurs; stall_cnt increments, saturating at 16'hFFFF.
  - After pushing i=msg_len-1: repeat=1 wraps i to 0 and stays in STREAM; repeat=0 enters DONE after the pio_action=0 cycle.
- DONE: done=1 for one cycle, pio_action=0, then IDLE.
- abort, any non-IDLE state: next edge gives pio_action=0, state IDLE, done=0; stall_cnt is held. Reset has priority over abort.
- Simultaneous start and abort in IDLE: abort wins, start is ignored.
- Indices wrap modulo memory depth. A length equal to the depth addresses every entry exactly once.

Decomposition:
- Package pio_seq_pkg:
  - action codes ACT_NOP=0, ACT_INSTR=1, ACT_PUSH=4;
  - state enum IDLE/LOAD_PROG/LOAD_CONF/STREAM/DONE;
  - wr_sel codes SEL_PROG/SEL_CONF/SEL_MSG.
- One natural sub-module: pio_seq_mem, a generic single-write-port, async-read reg array parametrised by width and depth, instantiated three times.

Test Plan:
- Write prog[k]=16'hE000+k for k=0..31, start with conf_len=0, msg_len=0 -> 32 cycles of action=1 with index 0..31 and din=E000..E01F, then done pulse; total 34 cycles from start to done.
- Config 5 entries {4'h2,32'h0000_0001}..{4'h2,32'h0000_0005} -> exactly five cycles of action=2 with din 1..5, in order, after program load.
- msg "Hello World!\n" (13 bytes), gap=0, tx_full=0 -> 13 pushes, each 2 cycles apart, din low bytes 0x48..0x0A, then done.
- Same message with tx_full[2]=1 for 10 cycles at byte 3, mindex=2 -> no push during the hold, stall_cnt=10, bytes delivered in order, none lost or duplicated.
- repeat=1, msg_len=3 "ABC", gap=4 -> pushes every 5 cycles A,B,C,A,B...; abort mid-gap -> action=0 next cycle, busy=0, no done pulse.
- start while busy and host writes while busy -> no effect on sequence or memory; reset during STREAM -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/pio_seq_pkg.sv
// Shared codes for the PIO bring-up and streaming sequencer.
// Action codes, sequencer states and host write-port selectors.
package pio_seq_pkg;

  localparam logic [5:0] ACT_NOP   = 6'd0;
  localparam logic [5:0] ACT_INSTR = 6'd1;
  localparam logic [5:0] ACT_PUSH  = 6'd4;

  localparam logic [1:0] SEL_PROG = 2'd0;
  localparam logic [1:0] SEL_CONF = 2'd1;
  localparam logic [1:0] SEL_MSG  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_PROG,
    LOAD_CONF,
    STREAM,
    DONE
  } state_t;

endpackage

// File: rtl/pio_seq_mem.sv
// Single write port register array with asynchronous read.
// Contents are never reset; the host reloads them as needed.
module pio_seq_mem #(
  parameter int W  = 8,
  parameter int D  = 32,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [D];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pio_stream_seq.sv
// Loads a PIO program and config list, then streams a message
// into one state machine's TX FIFO with pacing and repeat.
module pio_stream_seq
  import pio_seq_pkg::*;
#(
  parameter int PROG_LEN = 32,
  parameter int CONF_MAX = 32,
  parameter int MSG_MAX  = 64,
  parameter int GAP_W    = 12,
  localparam int CAW = $clog2(CONF_MAX),
  localparam int MAW = $clog2(MSG_MAX),
  localparam int CLW = CAW + 1,
  localparam int MLW = MAW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [5:0]       wr_addr,
  input  logic [35:0]      wr_data,
  input  logic             start,
  input  logic [1:0]       cfg_mindex,
  input  logic [CLW-1:0]   cfg_conf_len,
  input  logic [MLW-1:0]   cfg_msg_len,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic             cfg_repeat,
  input  logic             abort,
  output logic [5:0]       pio_action,
  output logic [31:0]      pio_din,
  output logic [4:0]       pio_index,
  output logic [1:0]       pio_mindex,
  input  logic [3:0]       pio_tx_full,
  output logic             busy,
  output logic             done,
  output logic [15:0]      stall_cnt
);

  localparam logic [4:0] P_LAST = 5'(PROG_LEN - 1);

  state_t           state;
  logic [4:0]       p;
  logic [CLW-1:0]   c;
  logic [MLW-1:0]   i;
  logic [GAP_W-1:0] gap_cnt;
  logic             fin;

  logic [CLW-1:0]   conf_len_q;
  logic [MLW-1:0]   msg_len_q;
  logic [GAP_W-1:0] gap_q;
  logic             repeat_q;
  logic [1:0]       mindex_q;

  logic [15:0] prog_rd;
  logic [35:0] conf_rd;
  logic [7:0]  msg_rd;
  logic        wr_ok;
  logic [GAP_W-1:0] gap_ld;

  assign busy   = (state != IDLE);
  assign wr_ok  = wr_en && (state == IDLE);
  assign gap_ld = (gap_q == '0) ? GAP_W'(1) : gap_q;

  pio_seq_mem #(.W(16), .D(32)) u_prog (
    .clk   (clk),
    .we    (wr_ok && wr_sel == SEL_PROG),
    .waddr (wr_addr[4:0]),
    .wdata (wr_data[15:0]),
    .raddr (p),
    .rdata (prog_rd)
  );

  pio_seq_mem #(.W(36), .D(CONF_MAX)) u_conf (
    .clk   (clk),
    .we    (wr_ok && wr_sel == SEL_CONF),
    .waddr (wr_addr[CAW-1:0]),
    .wdata (wr_data),
    .raddr (c[CAW-1:0]),
    .rdata (conf_rd)
  );

  pio_seq_mem #(.W(8), .D(MSG_MAX)) u_msg (
    .clk   (clk),
    .we    (wr_ok && wr_sel == SEL_MSG),
    .waddr (wr_addr[MAW-1:0]),
    .wdata (wr_data[7:0]),
    .raddr (i[MAW-1:0]),
    .rdata (msg_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pio_action <= ACT_NOP;
      pio_din    <= '0;
      pio_index  <= '0;
      pio_mindex <= '0;
      done       <= 1'b0;
      stall_cnt  <= '0;
      p          <= '0;
      c          <= '0;
      i          <= '0;
      gap_cnt    <= '0;
      fin        <= 1'b0;
      conf_len_q <= '0;
      msg_len_q  <= '0;
      gap_q      <= '0;
      repeat_q   <= 1'b0;
      mindex_q   <= '0;
    end else if (abort && state != IDLE) begin
      state      <= IDLE;
      pio_action <= ACT_NOP;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      pio_action <= ACT_NOP;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            conf_len_q <= cfg_conf_len;
            msg_len_q  <= cfg_msg_len;
            gap_q      <= cfg_gap;
            repeat_q   <= cfg_repeat;
            mindex_q   <= cfg_mindex;
            stall_cnt  <= '0;
            p          <= '0;
            c          <= '0;
            i          <= '0;
            gap_cnt    <= '0;
            fin        <= 1'b0;
            state      <= LOAD_PROG;
          end
        end
        LOAD_PROG: begin
          pio_action <= ACT_INSTR;
          pio_index  <= p;
          pio_din    <= {16'b0, prog_rd};
          p          <= p + 5'd1;
          if (p == P_LAST) state <= LOAD_CONF;
        end
        // one NOP slot after the list always separates config from pushes
        LOAD_CONF: begin
          if (c == conf_len_q) begin
            state <= STREAM;
          end else begin
            pio_action <= {2'b00, conf_rd[35:32]};
            pio_din    <= conf_rd[31:0];
            c          <= c + CLW'(1);
          end
        end
        STREAM: begin
          pio_mindex <= mindex_q;
          if (msg_len_q == '0 || fin) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end else if (pio_tx_full[mindex_q]) begin
            if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
          end else begin
            pio_action <= ACT_PUSH;
            pio_din    <= {24'b0, msg_rd};
            gap_cnt    <= gap_ld;
            if (i == msg_len_q - MLW'(1)) begin
              i   <= '0;
              fin <= !repeat_q;
            end else begin
              i <= i + MLW'(1);
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_stream_seq.sv
// Directed bench for pio_stream_seq: load, config, stream,
// backpressure, repeat/abort, busy lockout and reset.
module tb_pio_stream_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [5:0]  wr_addr;
  logic [35:0] wr_data;
  logic        start;
  logic [1:0]  cfg_mindex;
  logic [5:0]  cfg_conf_len;
  logic [6:0]  cfg_msg_len;
  logic [11:0] cfg_gap;
  logic        cfg_repeat;
  logic        abort;
  logic [5:0]  pio_action;
  logic [31:0] pio_din;
  logic [4:0]  pio_index;
  logic [1:0]  pio_mindex;
  logic [3:0]  pio_tx_full;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] hello [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C,
    8'h6F, 8'h20, 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64,
    8'h21, 8'h0A};
  logic [7:0] abc [3] = '{8'h41, 8'h42, 8'h43};

  pio_stream_seq dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .cfg_mindex   (cfg_mindex),
    .cfg_conf_len (cfg_conf_len),
    .cfg_msg_len  (cfg_msg_len),
    .cfg_gap      (cfg_gap),
    .cfg_repeat   (cfg_repeat),
    .abort        (abort),
    .pio_action   (pio_action),
    .pio_din      (pio_din),
    .pio_index    (pio_index),
    .pio_mindex   (pio_mindex),
    .pio_tx_full  (pio_tx_full),
    .busy         (busy),
    .done         (done),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [5:0] a,
                    input logic [35:0] d);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [5:0] cl, input logic [6:0] ml,
                          input logic [11:0] g, input logic r,
                          input logic [1:0] mi);
    cfg_conf_len = cl;
    cfg_msg_len = ml;
    cfg_gap = g;
    cfg_repeat = r;
    cfg_mindex = mi;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic prog_phase();
    for (int k = 0; k < 32; k++) begin
      tick();
      chk("prog_act", 64'(pio_action), 64'(1));
      chk("prog_idx", 64'(pio_index), 64'(k));
      chk("prog_din", 64'(pio_din), 64'(32'hE000 + k));
    end
  endtask

  task automatic push_bytes(input int lo, input int hi, input int n,
                            input logic [1:0] mi);
    for (int b = lo; b <= hi; b++) begin
      tick();
      chk("push_act", 64'(pio_action), 64'(4));
      chk("push_din", 64'(pio_din), 64'({24'b0, hello[b]}));
      chk("push_mi", 64'(pio_mindex), 64'(mi));
      tick();
      chk("gap_act", 64'(pio_action), 64'(0));
      chk("gap_done", 64'(done), 64'(b == n - 1));
    end
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    wr_sel = '0;
    wr_addr = '0;
    wr_data = '0;
    start = 1'b0;
    abort = 1'b0;
    cfg_mindex = '0;
    cfg_conf_len = '0;
    cfg_msg_len = '0;
    cfg_gap = '0;
    cfg_repeat = 1'b0;
    pio_tx_full = '0;
    tick();
    tick();
    chk("rst_act", 64'(pio_action), 64'(0));
    chk("rst_din", 64'(pio_din), 64'(0));
    chk("rst_idx", 64'(pio_index), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_stall", 64'(stall_cnt), 64'(0));
    reset = 1'b0;

    for (int k = 0; k < 32; k++) wr(2'd0, 6'(k), 36'(16'hE000 + k));
    for (int k = 0; k < 5; k++) wr(2'd1, 6'(k), {4'h2, 32'(k + 1)});
    for (int k = 0; k < 13; k++) wr(2'd2, 6'(k), 36'(hello[k]));

    // A: program only; mid-load start, write and cfg change must not matter
    do_start(6'd0, 7'd0, 12'd0, 1'b0, 2'd0);
    chk("a_busy", 64'(busy), 64'(1));
    for (int k = 0; k < 32; k++) begin
      if (k == 10) begin
        start = 1'b1;
        wr_en = 1'b1;
        wr_sel = 2'd0;
        wr_addr = 6'd20;
        wr_data = 36'h1234;
        cfg_conf_len = 6'd5;
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      chk("a_act", 64'(pio_action), 64'(1));
      chk("a_idx", 64'(pio_index), 64'(k));
      chk("a_din", 64'(pio_din), 64'(32'hE000 + k));
    end
    tick();
    chk("a_nop", 64'(pio_action), 64'(0));
    chk("a_early_done", 64'(done), 64'(0));
    tick();
    chk("a_done", 64'(done), 64'(1));
    chk("a_done_act", 64'(pio_action), 64'(0));
    chk("a_done_busy", 64'(busy), 64'(1));
    tick();
    chk("a_done_off", 64'(done), 64'(0));
    chk("a_idle", 64'(busy), 64'(0));

    // B: five config entries, then one NOP, then done
    do_start(6'd5, 7'd0, 12'd0, 1'b0, 2'd0);
    prog_phase();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("b_act", 64'(pio_action), 64'(2));
      chk("b_din", 64'(pio_din), 64'(k + 1));
    end
    tick();
    chk("b_nop", 64'(pio_action), 64'(0));
    chk("b_nop_done", 64'(done), 64'(0));
    tick();
    chk("b_done", 64'(done), 64'(1));
    tick();
    chk("b_idle", 64'(busy), 64'(0));

    // C: 13-byte message, gap 0, other machines' full flags set
    pio_tx_full = 4'b1101;
    do_start(6'd0, 7'd13, 12'd0, 1'b0, 2'd1);
    prog_phase();
    tick();
    chk("c_nop", 64'(pio_action), 64'(0));
    push_bytes(0, 12, 13, 2'd1);
    tick();
    chk("c_idle", 64'(busy), 64'(0));
    chk("c_done_off", 64'(done), 64'(0));
    chk("c_stall", 64'(stall_cnt), 64'(0));

    // D: backpressure on machine 2 for 10 cycles before byte 3
    pio_tx_full = 4'b1011;
    do_start(6'd0, 7'd13, 12'd0, 1'b0, 2'd2);
    prog_phase();
    tick();
    push_bytes(0, 2, 13, 2'd2);
    pio_tx_full = 4'b1111;
    for (int s = 0; s < 10; s++) begin
      tick();
      chk("d_hold_act", 64'(pio_action), 64'(0));
    end
    chk("d_stall", 64'(stall_cnt), 64'(10));
    pio_tx_full = 4'b1011;
    push_bytes(3, 12, 13, 2'd2);
    chk("d_stall_end", 64'(stall_cnt), 64'(10));
    tick();
    chk("d_idle", 64'(busy), 64'(0));

    // E: repeat "ABC" with gap 4, abort in the middle of a gap
    pio_tx_full = 4'b0000;
    for (int k = 0; k < 3; k++) wr(2'd2, 6'(k), 36'(abc[k]));
    do_start(6'd0, 7'd3, 12'd4, 1'b1, 2'd0);
    chk("e_stall_clr", 64'(stall_cnt), 64'(0));
    prog_phase();
    tick();
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("e_push_act", 64'(pio_action), 64'(4));
      chk("e_push_din", 64'(pio_din), 64'(abc[n % 3]));
      if (n < 4) begin
        for (int g = 0; g < 4; g++) begin
          tick();
          chk("e_gap_act", 64'(pio_action), 64'(0));
        end
      end
    end
    tick();
    tick();
    chk("e_gap2_act", 64'(pio_action), 64'(0));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("e_abort_act", 64'(pio_action), 64'(0));
    chk("e_abort_busy", 64'(busy), 64'(0));
    chk("e_abort_done", 64'(done), 64'(0));
    tick();
    chk("e_after_done", 64'(done), 64'(0));
    chk("e_after_act", 64'(pio_action), 64'(0));

    // F: reset while streaming, then start+abort, then memories kept
    do_start(6'd0, 7'd3, 12'd0, 1'b1, 2'd3);
    prog_phase();
    tick();
    tick();
    chk("f_push_act", 64'(pio_action), 64'(4));
    chk("f_push_din", 64'(pio_din), 64'(8'h41));
    chk("f_push_mi", 64'(pio_mindex), 64'(3));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("f_rst_act", 64'(pio_action), 64'(0));
    chk("f_rst_din", 64'(pio_din), 64'(0));
    chk("f_rst_mi", 64'(pio_mindex), 64'(0));
    chk("f_rst_idx", 64'(pio_index), 64'(0));
    chk("f_rst_busy", 64'(busy), 64'(0));
    chk("f_rst_done", 64'(done), 64'(0));
    chk("f_rst_stall", 64'(stall_cnt), 64'(0));
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("f_sa_busy", 64'(busy), 64'(0));
    tick();
    chk("f_sa_busy2", 64'(busy), 64'(0));
    do_start(6'd0, 7'd0, 12'd0, 1'b0, 2'd0);
    prog_phase();
    tick();
    tick();
    chk("f_keep_done", 64'(done), 64'(1));
    tick();
    chk("f_keep_idle", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
